mem_arbiter: RTL

Single-port memory arbiter between the core and main memory. It shares one memory request channel among three requesters: I-cache line fill, D-cache line fill and D-cache word write-back. It sits between the cache miss handlers and the memory bus. It serialises transactions with one outstanding at a time and steers burst read data back to the owning cache.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_picker.sv | 46 ++++
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration in mem_arb_picker.
package mem_arb_pkg;

    localparam int unsigned NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    // Encoding doubles as the bit index into the request vector.
    typedef enum logic [1:0] {
        REQ_DWR = 2'd0,
        REQ_DRD = 2'd1,
        REQ_IRD = 2'd2
    } req_e;

    // Successor modulo NUM_REQ.
    function automatic req_e next_req(input req_e r);
        return (r == REQ_IRD) ? REQ_DWR : req_e'(r + 2'd1);
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection among the three requesters.
// Build option: MEM_ARB_RR_EN defined -> round-robin search starting at ptr;
// undefined -> fixed priority D-write > D-read > I-read (no ptr port).
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
`ifdef MEM_ARB_RR_EN
    input  req_e               ptr,
`endif
    output logic               valid,
    output req_e               winner
);

`ifdef MEM_ARB_RR_EN
    req_e cand;

    // Search ptr, ptr+1, ptr+2 (mod 3); first asserted request wins.
    always_comb begin
        valid  = 1'b0;
        winner = REQ_DWR;
        cand   = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
            cand = next_req(cand);
        end
    end
`else
    // Fixed priority: lowest index wins.
    always_comb begin
        valid  = |req;
        winner = REQ_DWR;
        if (req[REQ_DWR]) begin
            winner = REQ_DWR;
        end else if (req[REQ_DRD]) begin
            winner = REQ_DRD;
        end else if (req[REQ_IRD]) begin
            winner = REQ_IRD;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises I-fill, D-fill and D-write-back onto one
// memory request channel, one transaction outstanding, and steers burst read data
// back to the owning cache.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (default: fixed priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rd_req,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  i_rd_gnt,
    output logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  i_rd_data_valid,
    input  logic                  d_rd_req,
    input  logic [ADDR_WIDTH-1:0] d_rd_addr,
    output logic                  d_rd_gnt,
    output logic [DATA_WIDTH-1:0] d_rd_data,
    output logic                  d_rd_data_valid,
    input  logic                  d_wr_req,
    input  logic [ADDR_WIDTH-1:0] d_wr_addr,
    input  logic [DATA_WIDTH-1:0] d_wr_data,
    output logic                  d_wr_gnt,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  protocol_err
);

    // One extra bit so the counter can hold BURST_LEN itself without wrapping.
    localparam int unsigned        CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(BURST_LEN);

    state_e                state_q, state_d;
    req_e                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  i_dv_q, d_dv_q;
    logic                  err_q;

    logic [NUM_REQ-1:0]    req_vec;
    logic                  pick_valid;
    req_e                  pick_winner;
    logic                  rsp_take;

    assign req_vec  = {i_rd_req, d_rd_req, d_wr_req};
    assign rsp_take = (state_q == RESP) && mem_rsp_valid;

`ifdef MEM_ARB_RR_EN
    req_e ptr_q, ptr_d;

    mem_arb_picker u_picker (
        .req    (req_vec),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );
`else
    mem_arb_picker u_picker (
        .req    (req_vec),
        .valid  (pick_valid),
        .winner (pick_winner)
    );
`endif

    // FSM next state, request latching and beat counting.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
`ifdef MEM_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    state_d = ISSUE;
`ifdef MEM_ARB_RR_EN
                    ptr_d   = next_req(pick_winner);
`endif
                    case (pick_winner)
                        REQ_DWR: begin
                            addr_d  = d_wr_addr;
                            we_d    = 1'b1;
                            wdata_d = d_wr_data;
                        end
                        REQ_DRD: begin
                            addr_d  = d_rd_addr;
                            we_d    = 1'b0;
                            wdata_d = '0;
                        end
                        default: begin
                            addr_d  = i_rd_addr;
                            we_d    = 1'b0;
                            wdata_d = '0;
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    if (we_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end
                end
            end
            RESP: begin
                if (mem_rsp_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= REQ_DWR;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin pointer, advanced when a request is latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_DWR;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Register each accepted beat and steer its strobe to the owner only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            i_dv_q     <= 1'b0;
            d_dv_q     <= 1'b0;
        end else begin
            i_dv_q <= rsp_take && (owner_q == REQ_IRD);
            d_dv_q <= rsp_take && (owner_q == REQ_DRD);
            if (rsp_take) begin
                rsp_data_q <= mem_rsp_data;
            end
        end
    end

    // Sticky flag for beats arriving when no read is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (mem_rsp_valid && (state_q != RESP)) begin
            err_q <= 1'b1;
        end
    end

    // Request channel outputs; grants are combinational so they align with the handshake.
    always_comb begin
        mem_req_valid   = (state_q == ISSUE);
        mem_req_we      = we_q;
        mem_req_addr    = addr_q;
        mem_req_wdata   = wdata_q;
        d_wr_gnt        = mem_req_valid && mem_req_ready && (owner_q == REQ_DWR);
        d_rd_gnt        = mem_req_valid && mem_req_ready && (owner_q == REQ_DRD);
        i_rd_gnt        = mem_req_valid && mem_req_ready && (owner_q == REQ_IRD);
        i_rd_data       = rsp_data_q;
        d_rd_data       = rsp_data_q;
        i_rd_data_valid = i_dv_q;
        d_rd_data_valid = d_dv_q;
        protocol_err    = err_q;
    end

endmodule
